// File: rtl/nn_cost_diff_multi.sv
// nn_cost_diff_multi
//   Multi-channel stochastic cost/error generator for the output layer.
//   Each channel accumulates the signed difference between a sign-magnitude
//   activation stream and a (caller pre-inverted) target stream in a
//   saturating accumulator. It emits an AND-filtered sign-magnitude error
//   stream. A shared window counter latches a per-channel net signed count of
//   the emitted error bits every WIN_LEN enabled cycles.
//
//   Optional feature: define COST_LEAK_EN to add a leak. Every 2^LEAK_SHIFT
//   enabled cycles, each accumulator moves one step toward zero.
//
//   Control priority: INIT_N (async) > EN low (full hold) > CLR > normal update.
module nn_cost_diff_multi #(
  parameter int N_CH          = 4,
  parameter int ACC_W         = 3,
  parameter int DIFFCOUNT_MIN = 1,
  parameter int MEMSIZE       = 4,
  parameter int WIN_LEN       = 256,
  parameter int CNT_W         = 10,
  parameter int LEAK_SHIFT    = 4
) (
  input  logic                    CLK,
  input  logic                    INIT_N,
  input  logic                    EN,
  input  logic                    CLR,
  input  logic [N_CH-1:0]         A,
  input  logic [N_CH-1:0]         A_SIGN,
  input  logic [N_CH-1:0]         Y,
  input  logic [N_CH-1:0]         Y_SIGN,
  output logic [N_CH-1:0]         OUT,
  output logic [N_CH-1:0]         SIGN_out,
  output logic [N_CH-1:0]         SAT,
  output logic [N_CH*CNT_W-1:0]   ERR_COUNT,
  output logic                    WIN_VALID
);

  // Accumulator is (ACC_W+1)-bit two's complement. The sum is formed one
  // bit wider so that ACC+D cannot wrap before the clamp.
  localparam int AW1  = ACC_W + 1;
  localparam int SW   = ACC_W + 2;
  localparam int WC_W = $clog2(WIN_LEN);

  localparam logic signed [SW-1:0]    LIM           = SW'((2 ** ACC_W) - 1);
  localparam logic signed [SW-1:0]    NEG_LIM       = -LIM;
  localparam logic [AW1-1:0]          DMIN          = AW1'(DIFFCOUNT_MIN);
  localparam logic [WC_W-1:0]         WIN_LAST      = WC_W'(WIN_LEN - 1);
  localparam logic [WC_W-1:0]         WIN_ONE       = WC_W'(1);
  localparam logic signed [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic signed [CNT_W-1:0] CNT_MINUS_ONE = -CNT_ONE;

  // Elaboration-time parameter sanity checks.
  if (MEMSIZE < 2) begin : g_bad_memsize
    $error("nn_cost_diff_multi: MEMSIZE must be at least 2");
  end
  if (WIN_LEN < 2) begin : g_bad_win_len
    $error("nn_cost_diff_multi: WIN_LEN must be at least 2");
  end
  if (((2 ** (CNT_W - 1)) - 1) < WIN_LEN) begin : g_bad_cnt_w
    $error("nn_cost_diff_multi: CNT_W too narrow for WIN_LEN");
  end
  if (LEAK_SHIFT < 1) begin : g_bad_leak_shift
    $error("nn_cost_diff_multi: LEAK_SHIFT must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Shared window counter
  // ---------------------------------------------------------------------------
  logic [WC_W-1:0] win_cnt_q;
  logic            win_valid_q;
  logic            win_wrap;

  assign win_wrap  = (win_cnt_q == WIN_LAST);
  assign WIN_VALID = win_valid_q;

  // Window cycle counter and the one-cycle update strobe. CLR restarts the
  // window without a strobe. EN low freezes the count and drops the strobe.
  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      win_cnt_q   <= '0;
      win_valid_q <= 1'b0;
    end else if (EN) begin
      if (CLR) begin
        win_cnt_q   <= '0;
        win_valid_q <= 1'b0;
      end else begin
        win_cnt_q   <= win_wrap ? '0 : (win_cnt_q + WIN_ONE);
        win_valid_q <= win_wrap;
      end
    end else begin
      win_valid_q <= 1'b0;
    end
  end

`ifdef COST_LEAK_EN
  // ---------------------------------------------------------------------------
  // Leak timer: fires on the last count of every 2^LEAK_SHIFT enabled cycles
  // ---------------------------------------------------------------------------
  localparam logic [LEAK_SHIFT-1:0] LEAK_ONE = LEAK_SHIFT'(1);
  localparam logic signed [SW-1:0]  ONE_S    = SW'(1);

  logic [LEAK_SHIFT-1:0] leak_cnt_q;
  logic                  leak_fire;

  assign leak_fire = &leak_cnt_q;

  // Free-running leak counter, restarted by CLR.
  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      leak_cnt_q <= '0;
    end else if (EN) begin
      leak_cnt_q <= CLR ? '0 : (leak_cnt_q + LEAK_ONE);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Per-channel datapath
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic signed [AW1-1:0]   acc_q;
    logic                    sign_q;
    logic                    sat_q;
    logic [MEMSIZE-1:0]      mem_q;
    logic signed [CNT_W-1:0] wacc_q;
    logic signed [CNT_W-1:0] err_q;

    logic                    a_p, a_n, y_p, y_n;
    logic                    pos, neg, raw, in_bit, out_bit, sat_hit;
    logic signed [SW-1:0]    d, sum, clamped, acc_nxt;
    logic [AW1-1:0]          acc_abs;
    logic signed [CNT_W-1:0] contrib, wacc_nxt;

    // Step D, clamped (and optionally leaked) next ACC, gated filter input,
    // and this cycle's contribution to the window count.
    always_comb begin
      a_p = A[c] & ~A_SIGN[c];
      a_n = A[c] &  A_SIGN[c];
      y_p = Y[c] & ~Y_SIGN[c];
      y_n = Y[c] &  Y_SIGN[c];

      d   = SW'(a_p) + SW'(y_p) - SW'(a_n) - SW'(y_n);
      sum = {acc_q[AW1-1], acc_q} + d;

      if (sum > LIM) begin
        clamped = LIM;
      end else if (sum < NEG_LIM) begin
        clamped = NEG_LIM;
      end else begin
        clamped = sum;
      end

      acc_nxt = clamped;
`ifdef COST_LEAK_EN
      // Leak moves one step toward zero and never crosses it.
      if (leak_fire) begin
        if (clamped[SW-1]) begin
          acc_nxt = clamped + ONE_S;
        end else if (clamped != '0) begin
          acc_nxt = clamped - ONE_S;
        end
      end
`endif

      sat_hit = (acc_nxt == LIM) || (acc_nxt == NEG_LIM);

      // Gating looks at the current ACC, not the next one.
      acc_abs = acc_q[AW1-1] ? -acc_q : acc_q;
      pos     = a_p | y_p;
      neg     = a_n | y_n;
      raw     = sign_q ? (neg & ~pos) : (pos & ~neg);
      in_bit  = (acc_abs > DMIN) ? raw : 1'b0;

      out_bit = &mem_q;
      contrib = '0;
      if (out_bit) begin
        contrib = sign_q ? CNT_MINUS_ONE : CNT_ONE;
      end
      wacc_nxt = wacc_q + contrib;
    end

    // Channel state. SIGN survives CLR. ERR_COUNT latches only on a window
    // wrap and survives CLR.
    always_ff @(posedge CLK or negedge INIT_N) begin
      if (!INIT_N) begin
        acc_q  <= '0;
        sign_q <= 1'b0;
        sat_q  <= 1'b0;
        mem_q  <= '0;
        wacc_q <= '0;
        err_q  <= '0;
      end else if (EN) begin
        if (CLR) begin
          acc_q  <= '0;
          sat_q  <= 1'b0;
          mem_q  <= '0;
          wacc_q <= '0;
        end else begin
          acc_q <= acc_nxt[AW1-1:0];
          if (acc_nxt != '0) begin
            sign_q <= acc_nxt[SW-1];
          end
          if (sat_hit) begin
            sat_q <= 1'b1;
          end
          mem_q <= {mem_q[MEMSIZE-2:0], in_bit};
          if (win_wrap) begin
            err_q  <= wacc_nxt;
            wacc_q <= '0;
          end else begin
            wacc_q <= wacc_nxt;
          end
        end
      end
    end

    assign OUT[c]                     = out_bit;
    assign SIGN_out[c]                = sign_q;
    assign SAT[c]                     = sat_q;
    assign ERR_COUNT[c*CNT_W +: CNT_W] = err_q;
  end

endmodule

// File: tb/tb_nn_cost_diff_multi.sv
// tb_nn_cost_diff_multi: directed bench for nn_cost_diff_multi with WIN_LEN=8
// and LEAK_SHIFT=2. The leak scenario runs when COST_LEAK_EN is defined.
module tb_nn_cost_diff_multi;

  localparam int N_CH          = 4;
  localparam int ACC_W         = 3;
  localparam int DIFFCOUNT_MIN = 1;
  localparam int MEMSIZE       = 4;
  localparam int WIN_LEN       = 8;
  localparam int CNT_W         = 10;
  localparam int LEAK_SHIFT    = 2;

  logic                  CLK = 1'b0;
  logic                  INIT_N;
  logic                  EN;
  logic                  CLR;
  logic [N_CH-1:0]       A, A_SIGN, Y, Y_SIGN;
  logic [N_CH-1:0]       OUT, SIGN_out, SAT;
  logic [N_CH*CNT_W-1:0] ERR_COUNT;
  logic                  WIN_VALID;

  int errors = 0;
  int checks = 0;

  nn_cost_diff_multi #(
    .N_CH(N_CH), .ACC_W(ACC_W), .DIFFCOUNT_MIN(DIFFCOUNT_MIN),
    .MEMSIZE(MEMSIZE), .WIN_LEN(WIN_LEN), .CNT_W(CNT_W), .LEAK_SHIFT(LEAK_SHIFT)
  ) dut (
    .CLK(CLK), .INIT_N(INIT_N), .EN(EN), .CLR(CLR),
    .A(A), .A_SIGN(A_SIGN), .Y(Y), .Y_SIGN(Y_SIGN),
    .OUT(OUT), .SIGN_out(SIGN_out), .SAT(SAT),
    .ERR_COUNT(ERR_COUNT), .WIN_VALID(WIN_VALID)
  );

  // Clock and time limit
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    A = '0; A_SIGN = '0; Y = '0; Y_SIGN = '0;
  endtask

  task automatic pulse_clr();
    EN  = 1'b1;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  function automatic logic [N_CH*CNT_W-1:0] pack_err(int c0, int c1, int c2, int c3);
    return {CNT_W'(c3), CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
  endfunction

  // Reset values, then 20 cycles of EN=0 with random inputs
  task automatic test_reset();
    INIT_N = 1'b0; EN = 1'b0; CLR = 1'b0;
    A = N_CH'($urandom_range(0, 15)); A_SIGN = N_CH'($urandom_range(0, 15));
    Y = N_CH'($urandom_range(0, 15)); Y_SIGN = N_CH'($urandom_range(0, 15));
    #13;
    checks++;
    if ({OUT, SIGN_out, SAT} !== 12'h000) begin
      errors++; $display("FAIL reset_bits: got %h expected 000", {OUT, SIGN_out, SAT});
    end
    checks++;
    if (ERR_COUNT !== '0) begin
      errors++; $display("FAIL reset_err_count: got %h expected 0", ERR_COUNT);
    end
    checks++;
    if (WIN_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_win_valid: got %b expected 0", WIN_VALID);
    end
    @(negedge CLK);
    INIT_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      A = N_CH'($urandom_range(0, 15)); A_SIGN = N_CH'($urandom_range(0, 15));
      Y = N_CH'($urandom_range(0, 15)); Y_SIGN = N_CH'($urandom_range(0, 15));
      tick();
      checks++;
      if ({OUT, SIGN_out, SAT, WIN_VALID} !== 13'h0 || ERR_COUNT !== '0) begin
        errors++;
        $display("FAIL hold_after_reset cyc=%0d: got out=%b sign=%b sat=%b wv=%b err=%h expected all 0",
                 i, OUT, SIGN_out, SAT, WIN_VALID, ERR_COUNT);
      end
    end
  endtask

  // ch0 driven +1 every cycle: ACC 1..7, SAT at 7, OUT from ACC=6
  task automatic test_positive();
    idle_inputs();
    pulse_clr();
    A[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (SAT[0] !== (k >= 7)) begin
        errors++; $display("FAIL pos_sat k=%0d: got %b expected %b", k, SAT[0], (k >= 7));
      end
      checks++;
      if (OUT[0] !== (k >= 6)) begin
        errors++; $display("FAIL pos_out k=%0d: got %b expected %b", k, OUT[0], (k >= 6));
      end
      checks++;
      if (SIGN_out[0] !== 1'b0) begin
        errors++; $display("FAIL pos_sign k=%0d: got %b expected 0", k, SIGN_out[0]);
      end
    end
  endtask

  // ch1: +1, then D=-2 to -1, then D=+1 to 0 (sign held), then +1
  task automatic test_zero_cross();
    idle_inputs();
    pulse_clr();
    A[1] = 1'b1;
    tick();
    checks++;
    if (SIGN_out[1] !== 1'b0) begin
      errors++; $display("FAIL zc_plus1_sign: got %b expected 0", SIGN_out[1]);
    end
    A_SIGN[1] = 1'b1; Y[1] = 1'b1; Y_SIGN[1] = 1'b1;
    tick();
    checks++;
    if (SIGN_out[1] !== 1'b1) begin
      errors++; $display("FAIL zc_minus1_sign: got %b expected 1", SIGN_out[1]);
    end
    checks++;
    if (OUT[1] !== 1'b0 || SAT[1] !== 1'b0) begin
      errors++; $display("FAIL zc_minus1_out_sat: got out=%b sat=%b expected 0 0", OUT[1], SAT[1]);
    end
    A_SIGN[1] = 1'b0; Y[1] = 1'b0; Y_SIGN[1] = 1'b0;
    tick();
    checks++;
    if (SIGN_out[1] !== 1'b1) begin
      errors++; $display("FAIL zc_zero_sign_hold: got %b expected 1", SIGN_out[1]);
    end
    tick();
    checks++;
    if (SIGN_out[1] !== 1'b0) begin
      errors++; $display("FAIL zc_back_plus1_sign: got %b expected 0", SIGN_out[1]);
    end
  endtask

  // ch2: RAW pattern 1110 repeating; OUT never asserts, ACC still saturates
  task automatic test_filter_break();
    idle_inputs();
    pulse_clr();
    for (int i = 0; i < 32; i++) begin
      if ((i % 4) != 3) begin
        A[2] = 1'b1; A_SIGN[2] = 1'b0; Y[2] = 1'b0; Y_SIGN[2] = 1'b0;
      end else begin
        A[2] = 1'b1; A_SIGN[2] = 1'b1; Y[2] = 1'b1; Y_SIGN[2] = 1'b1;
      end
      tick();
      checks++;
      if (OUT[2] !== 1'b0) begin
        errors++; $display("FAIL filter_break i=%0d: got %b expected 0", i, OUT[2]);
      end
    end
    checks++;
    if (SAT[2] !== 1'b1) begin
      errors++; $display("FAIL filter_break_sat: got %b expected 1", SAT[2]);
    end
  endtask

  // Window: ch0 positive from edge 6 on, ch3 negative OUT in periods 8..10
  task automatic test_window();
    idle_inputs();
    pulse_clr();
    A[0] = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      tick();
      checks++;
      if (WIN_VALID !== (e == 8 || e == 16 || e == 24)) begin
        errors++; $display("FAIL win_valid e=%0d: got %b expected %b", e, WIN_VALID,
                           (e == 8 || e == 16 || e == 24));
      end
      checks++;
      if (OUT[0] !== (e >= 6) || OUT[3] !== (e >= 8 && e <= 10)) begin
        errors++; $display("FAIL win_out e=%0d: got ch0=%b ch3=%b expected %b %b", e, OUT[0], OUT[3],
                           (e >= 6), (e >= 8 && e <= 10));
      end
      if (e == 8) begin
        checks++;
        if (ERR_COUNT !== pack_err(2, 0, 0, 0)) begin
          errors++; $display("FAIL win1_count: got %h expected %h", ERR_COUNT, pack_err(2, 0, 0, 0));
        end
      end
      if (e == 16) begin
        checks++;
        if (ERR_COUNT !== pack_err(8, 0, 0, -3)) begin
          errors++; $display("FAIL win2_count: got %h expected %h", ERR_COUNT, pack_err(8, 0, 0, -3));
        end
      end
      if (e == 24) begin
        checks++;
        if (ERR_COUNT !== pack_err(8, 0, 0, 0)) begin
          errors++; $display("FAIL win3_count: got %h expected %h", ERR_COUNT, pack_err(8, 0, 0, 0));
        end
      end
      if (e == 2) begin
        A[3] = 1'b1; A_SIGN[3] = 1'b1;
      end
      if (e == 10) begin
        A[3] = 1'b0; A_SIGN[3] = 1'b0;
      end
    end
  endtask

  // EN=0 freezes everything including the window counter
  task automatic test_en_hold();
    EN = 1'b0;
    for (int i = 0; i < 12; i++) begin
      A = N_CH'($urandom_range(0, 15)); A_SIGN = N_CH'($urandom_range(0, 15));
      Y = N_CH'($urandom_range(0, 15)); Y_SIGN = N_CH'($urandom_range(0, 15));
      CLR = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (OUT !== 4'b0001 || SIGN_out !== 4'b1000 || SAT !== 4'b1001 || WIN_VALID !== 1'b0 ||
          ERR_COUNT !== pack_err(8, 0, 0, 0)) begin
        errors++;
        $display("FAIL en_hold i=%0d: got out=%b sign=%b sat=%b wv=%b err=%h expected 0001 1000 1001 0 %h",
                 i, OUT, SIGN_out, SAT, WIN_VALID, ERR_COUNT, pack_err(8, 0, 0, 0));
      end
    end
    CLR = 1'b0;
    idle_inputs();
    A[0] = 1'b1;
    EN = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (WIN_VALID !== (e == 8)) begin
        errors++; $display("FAIL en_hold_resume_wv e=%0d: got %b expected %b", e, WIN_VALID, (e == 8));
      end
    end
    checks++;
    if (ERR_COUNT !== pack_err(8, 0, 0, 0)) begin
      errors++; $display("FAIL en_hold_resume_count: got %h expected %h", ERR_COUNT, pack_err(8, 0, 0, 0));
    end
  endtask

  // CLR mid-window discards the partial count, holds ERR_COUNT and SIGN
  task automatic test_clr_window();
    for (int i = 0; i < 3; i++) tick();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    checks++;
    if (WIN_VALID !== 1'b0 || OUT !== 4'b0000 || SAT !== 4'b0000 || SIGN_out !== 4'b1000) begin
      errors++; $display("FAIL clr_state: got wv=%b out=%b sat=%b sign=%b expected 0 0000 0000 1000",
                         WIN_VALID, OUT, SAT, SIGN_out);
    end
    checks++;
    if (ERR_COUNT !== pack_err(8, 0, 0, 0)) begin
      errors++; $display("FAIL clr_err_hold: got %h expected %h", ERR_COUNT, pack_err(8, 0, 0, 0));
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (WIN_VALID !== (e == 8)) begin
        errors++; $display("FAIL clr_restart_wv e=%0d: got %b expected %b", e, WIN_VALID, (e == 8));
      end
    end
    checks++;
    if (ERR_COUNT !== pack_err(2, 0, 0, 0)) begin
      errors++; $display("FAIL clr_restart_count: got %h expected %h", ERR_COUNT, pack_err(2, 0, 0, 0));
    end
  endtask

  // Async reset mid-window drops the partial count
  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) tick();
    INIT_N = 1'b0;
    #2;
    checks++;
    if (ERR_COUNT !== '0 || {OUT, SIGN_out, SAT, WIN_VALID} !== 13'h0) begin
      errors++; $display("FAIL reset_mid: got out=%b sign=%b sat=%b wv=%b err=%h expected all 0",
                         OUT, SIGN_out, SAT, WIN_VALID, ERR_COUNT);
    end
    @(negedge CLK);
    INIT_N = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (WIN_VALID !== (e == 8)) begin
        errors++; $display("FAIL reset_mid_wv e=%0d: got %b expected %b", e, WIN_VALID, (e == 8));
      end
    end
    checks++;
    if (ERR_COUNT !== pack_err(2, 0, 0, 0)) begin
      errors++; $display("FAIL reset_mid_count: got %h expected %h", ERR_COUNT, pack_err(2, 0, 0, 0));
    end
  endtask

`ifdef COST_LEAK_EN
  // Leak: ACC=+3 then D=0; leaks at edges 4, 8, 12 take it to 0, then D=-1 gives -1
  task automatic test_leak();
    idle_inputs();
    pulse_clr();
    A[0] = 1'b1;
    for (int e = 1; e <= 3; e++) tick();
    A[0] = 1'b0;
    for (int e = 4; e <= 12; e++) begin
      tick();
      checks++;
      if (SIGN_out[0] !== 1'b0) begin
        errors++; $display("FAIL leak_sign_hold e=%0d: got %b expected 0", e, SIGN_out[0]);
      end
    end
    A[0] = 1'b1; A_SIGN[0] = 1'b1;
    tick();
    checks++;
    if (SIGN_out[0] !== 1'b1) begin
      errors++; $display("FAIL leak_reached_zero: got %b expected 1", SIGN_out[0]);
    end
  endtask
`endif

  // Sequencer and final report
  initial begin
    test_reset();
`ifdef COST_LEAK_EN
    test_leak();
`else
    test_positive();
    test_zero_cross();
    test_filter_break();
    test_window();
    test_en_hold();
    test_clr_window();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
